// File: rtl/wasm_mem_port.sv
// Load/store unit: turns byte-addressed 1/2/4-byte core accesses into word commands,
// with read-modify-write for partial stores and bounds/size trapping.
module wasm_mem_port #(
    parameter int unsigned MEM_WORDS = 2048
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_signed_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_trap_o,
    output logic        mem_cmd_start_o,
    input  logic        mem_cmd_ready_i,
    output logic        mem_cmd_write_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_rdata_ready_i
);

    localparam logic [32:0] BYTE_LIMIT = 33'(4 * MEM_WORDS);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_ISSUE, S_SETTLE, S_WAIT, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  step_q, step_d;
    logic [31:0] rd0_q, rd0_d;
    logic        mem_cmd_write_q, mem_cmd_write_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_trap_q, resp_trap_d;

    logic [1:0]  off;
    logic [29:0] w0;
    logic [3:0]  nbytes;
    logic [7:0]  lane_mask0, lane_mask;
    logic        spans, full_wr, trap;
    logic [1:0]  last_step;
    logic [63:0] bit_mask, st_pair;
    logic [32:0] end_addr;

    always_comb begin
        off = addr_q[1:0];
        w0  = addr_q[31:2];
        case (size_q)
            2'd0:    begin nbytes = 4'd1; lane_mask0 = 8'h01; end
            2'd1:    begin nbytes = 4'd2; lane_mask0 = 8'h03; end
            default: begin nbytes = 4'd4; lane_mask0 = 8'h0F; end
        endcase
        spans   = ({2'b00, off} + nbytes) > 4'd4;
        full_wr = write_q && (size_q == 2'd2) && (off == 2'd0);
        if (!write_q)
            last_step = {1'b0, spans};
        else if (full_wr)
            last_step = 2'd0;
        else
            last_step = spans ? 2'd3 : 2'd1;
        lane_mask = lane_mask0 << off;
        for (int i = 0; i < 8; i++)
            bit_mask[8*i +: 8] = {8{lane_mask[i]}};
        st_pair  = {32'h0, wdata_q} << {off, 3'b000};
        end_addr = {1'b0, addr_q} + {29'b0, nbytes};
        trap     = (size_q == 2'd3) || (end_addr > BYTE_LIMIT);
    end

    // Next command; RMW step order is read w0, write w0, read w1, write w1.
    logic [1:0]  cmd_step;
    logic        cmd_hi, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata, merge_lo, merge_hi;

    always_comb begin
        cmd_step  = (state_q == S_CHECK) ? 2'd0 : step_q + 2'd1;
        cmd_hi    = write_q ? cmd_step[1] : cmd_step[0];
        cmd_addr  = {2'b00, w0 + {29'b0, cmd_hi}};
        cmd_write = write_q && (full_wr || cmd_step[0]);
        merge_lo  = (mem_rdata_i & ~bit_mask[31:0])  | (st_pair[31:0]  & bit_mask[31:0]);
        merge_hi  = (mem_rdata_i & ~bit_mask[63:32]) | (st_pair[63:32] & bit_mask[63:32]);
        if (full_wr)
            cmd_wdata = wdata_q;
        else if (cmd_write)
            cmd_wdata = cmd_hi ? merge_hi : merge_lo;
        else
            cmd_wdata = 32'h0;
    end

    logic [63:0] ld_pair;
    logic [31:0] ld_shift, ld_val;

    always_comb begin
        ld_pair  = (step_q == 2'd1) ? {mem_rdata_i, rd0_q} : {32'h0, mem_rdata_i};
        ld_shift = 32'(ld_pair >> {off, 3'b000});
        case (size_q)
            2'd0:    ld_val = {{24{signed_q & ld_shift[7]}},  ld_shift[7:0]};
            2'd1:    ld_val = {{16{signed_q & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_val = ld_shift;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        write_d         = write_q;
        size_d          = size_q;
        signed_d        = signed_q;
        addr_d          = addr_q;
        wdata_d         = wdata_q;
        step_d          = step_q;
        rd0_d           = rd0_q;
        mem_cmd_write_d = mem_cmd_write_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        resp_rdata_d    = resp_rdata_q;
        resp_trap_d     = resp_trap_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    write_d  = req_write_i;
                    size_d   = req_size_i;
                    signed_d = req_signed_i;
                    addr_d   = req_addr_i;
                    wdata_d  = req_wdata_i;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (trap) begin
                    resp_trap_d  = 1'b1;
                    resp_rdata_d = 32'h0;
                    state_d      = S_RESP;
                end else begin
                    step_d          = 2'd0;
                    mem_cmd_write_d = cmd_write;
                    mem_addr_d      = cmd_addr;
                    mem_wdata_d     = cmd_wdata;
                    state_d         = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (mem_cmd_ready_i)
                    state_d = S_SETTLE;
            end
            S_SETTLE: state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rdata_ready_i) begin
                    if (!write_q && step_q == 2'd0)
                        rd0_d = mem_rdata_i;
                    if (step_q == last_step) begin
                        resp_trap_d  = 1'b0;
                        resp_rdata_d = write_q ? 32'h0 : ld_val;
                        state_d      = S_RESP;
                    end else begin
                        step_d          = step_q + 2'd1;
                        mem_cmd_write_d = cmd_write;
                        mem_addr_d      = cmd_addr;
                        mem_wdata_d     = cmd_wdata;
                        state_d         = S_ISSUE;
                    end
                end
            end
            S_RESP: begin
                resp_rdata_d = 32'h0;
                resp_trap_d  = 1'b0;
                state_d      = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q         <= S_IDLE;
            write_q         <= 1'b0;
            size_q          <= 2'd0;
            signed_q        <= 1'b0;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            step_q          <= 2'd0;
            rd0_q           <= 32'h0;
            mem_cmd_write_q <= 1'b0;
            mem_addr_q      <= 32'h0;
            mem_wdata_q     <= 32'h0;
            resp_rdata_q    <= 32'h0;
            resp_trap_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            write_q         <= write_d;
            size_q          <= size_d;
            signed_q        <= signed_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            step_q          <= step_d;
            rd0_q           <= rd0_d;
            mem_cmd_write_q <= mem_cmd_write_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            resp_rdata_q    <= resp_rdata_d;
            resp_trap_q     <= resp_trap_d;
        end
    end

    assign req_ready_o     = (state_q == S_IDLE);
    assign resp_valid_o    = (state_q == S_RESP);
    assign mem_cmd_start_o = (state_q == S_ISSUE);
    assign mem_cmd_write_o = mem_cmd_write_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign resp_rdata_o    = resp_rdata_q;
    assign resp_trap_o     = resp_trap_q;

endmodule
